fft_oflow_ctrl: RTL and testbench

Window controller for the PFB/FFT overflow monitor. Watches the per-lane FFT overflow flags, aligns to the FFT frame sync and integrates over a programmable number of frames. At the end of each window it publishes one packed 32-bit status word, which drives user_data_in of the software-readable overflow register on user_clk. Sequencing, window alignment, saturation and clear handling all live here, so software samples consistent per-window snapshots instead of raw flags.

---
 rtl/fft_oflow_ctrl_pkg.sv | 22 ++
 rtl/fft_oflow_ctrl_if.sv | 24 ++
 rtl/fft_oflow_ctrl_sat_counter.sv | 25 ++
 rtl/fft_oflow_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fft_oflow_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_oflow_ctrl_pkg.sv
// Shared types, status-word field layout and saturation helper for the FFT overflow window controller.
package fft_oflow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ACCUM = 2'd2
    } state_t;

    localparam int STS_STICKY   = 31;
    localparam int STS_SEQ_LSB  = 28;
    localparam int STS_MASK_LSB = 24;
    localparam int STS_FRM_LSB  = 12;
    localparam int STS_SAMP_LSB = 0;

    localparam logic [11:0] CNT_MAX = 12'hFFF;

    function automatic logic [11:0] sat_inc(input logic [11:0] v, input logic inc);
        return (inc && (v != CNT_MAX)) ? v + 12'd1 : v;
    endfunction

endpackage

// File: rtl/fft_oflow_ctrl_if.sv
// Control, FFT-side flag and status-word signals of the overflow window controller.
interface fft_oflow_ctrl_if #(
    parameter int NUM_LANES = 4,
    parameter int WIN_W     = 16
);
    logic                 enable;
    logic                 clear;
    logic [WIN_W-1:0]     win_frames;
    logic                 fft_sync;
    logic [NUM_LANES-1:0] fft_oflow;
    logic [31:0]          status_word;
    logic                 status_valid;
    logic                 sticky_oflow;

    modport master (
        output enable, clear, win_frames, fft_sync, fft_oflow,
        input  status_word, status_valid, sticky_oflow
    );

    modport slave (
        input  enable, clear, win_frames, fft_sync, fft_oflow,
        output status_word, status_valid, sticky_oflow
    );
endinterface

// File: rtl/fft_oflow_ctrl_sat_counter.sv
// Loadable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 12
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/fft_oflow_ctrl.sv
// Overflow window controller: aligns to FFT frame sync, integrates lane overflow flags
// over win_frames frames and publishes one packed status word per window.
module fft_oflow_ctrl
    import fft_oflow_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int WIN_W     = 16,
    parameter int CNT_W     = 12
) (
    input  logic            user_clk,
    input  logic            user_rst_n,
    fft_oflow_ctrl_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIN_W-1:0] r_win_len;
    logic [WIN_W-1:0] r_frame_cnt;
    logic [WIN_W-1:0] w_win_len_new;
    logic             r_frame_oflow;
    logic             r_sticky;
    logic             r_status_valid;
    logic [3:0]       r_lane_mask;
    logic [3:0]       w_mask_in;
    logic [2:0]       r_seq;
    logic [31:0]      r_status;
    logic [31:0]      w_status_nxt;
    logic [CNT_W-1:0] w_frm_cnt;
    logic [CNT_W-1:0] w_samp_cnt;
    logic [CNT_W-1:0] w_frm_new;
    logic [CNT_W-1:0] w_samp_load;
    logic             w_any;
    logic             w_flush;
    logic             w_start;
    logic             w_sync_acc;
    logic             w_win_close;
    logic             w_active;
    logic             w_sticky_nxt;
    logic             w_frm_inc;
    logic             w_samp_inc;
    logic             w_acc_load;

    assign w_any         = |bus.fft_oflow;
    assign w_mask_in     = 4'(bus.fft_oflow);
    assign w_flush       = bus.clear || !bus.enable;
    assign w_win_len_new = (bus.win_frames == '0) ? WIN_W'(1) : bus.win_frames;

    // enable=0 and clear both pre-empt any sync/flag activity in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_sync_acc  = 1'b0;
        w_win_close = 1'b0;
        w_active    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.enable && !bus.clear) w_state_nxt = ALIGN;
            end
            ALIGN: begin
                if (!bus.enable) begin
                    w_state_nxt = IDLE;
                end else if (!bus.clear && bus.fft_sync) begin
                    w_state_nxt = ACCUM;
                    w_start     = 1'b1;
                    w_active    = 1'b1;
                end
            end
            ACCUM: begin
                if (!bus.enable) begin
                    w_state_nxt = IDLE;
                end else if (bus.clear) begin
                    w_state_nxt = ALIGN;
                end else begin
                    w_active    = 1'b1;
                    w_sync_acc  = bus.fft_sync;
                    w_win_close = bus.fft_sync && (r_frame_cnt == (r_win_len - WIN_W'(1)));
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) r_state <= IDLE;
        else             r_state <= w_state_nxt;
    end

    assign w_sticky_nxt = r_sticky | (w_active & w_any);
    assign w_frm_new    = sat_inc(w_frm_cnt, r_frame_oflow);
    assign w_frm_inc    = w_sync_acc && !w_win_close && r_frame_oflow;
    assign w_samp_inc   = w_active && !w_start && !w_win_close && w_any;
    assign w_acc_load   = w_flush || w_start || w_win_close;
    // a window start or restart seeds the sample count with the sync cycle's own flags
    assign w_samp_load  = CNT_W'(w_any && !w_flush);

    sat_counter #(.CNT_W(CNT_W)) u_frm_cnt (
        .i_clk      (user_clk),
        .i_rst_n    (user_rst_n),
        .i_inc      (w_frm_inc),
        .i_load     (w_acc_load),
        .i_load_val ('0),
        .o_cnt      (w_frm_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_samp_cnt (
        .i_clk      (user_clk),
        .i_rst_n    (user_rst_n),
        .i_inc      (w_samp_inc),
        .i_load     (w_acc_load),
        .i_load_val (w_samp_load),
        .o_cnt      (w_samp_cnt)
    );

    always_comb begin
        w_status_nxt                                = '0;
        w_status_nxt[STS_STICKY]                    = w_sticky_nxt;
        w_status_nxt[STS_SEQ_LSB +: 3]              = r_seq;
        w_status_nxt[STS_MASK_LSB +: 4]             = r_lane_mask;
        w_status_nxt[STS_FRM_LSB +: CNT_W]          = w_frm_new;
        w_status_nxt[STS_SAMP_LSB +: CNT_W]         = w_samp_cnt;
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_win_len      <= '0;
            r_frame_cnt    <= '0;
            r_frame_oflow  <= 1'b0;
            r_lane_mask    <= '0;
            r_sticky       <= 1'b0;
            r_seq          <= '0;
            r_status       <= '0;
            r_status_valid <= 1'b0;
        end else begin
            r_status_valid <= w_win_close;
            if (bus.clear) begin
                r_frame_cnt   <= '0;
                r_frame_oflow <= 1'b0;
                r_lane_mask   <= '0;
                r_sticky      <= 1'b0;
                r_seq         <= '0;
                r_status      <= '0;
            end else if (!bus.enable) begin
                r_frame_cnt   <= '0;
                r_frame_oflow <= 1'b0;
                r_lane_mask   <= '0;
            end else begin
                r_sticky <= w_sticky_nxt;
                if (w_win_close) begin
                    r_status <= w_status_nxt;
                    r_seq    <= r_seq + 3'd1;
                end
                if (w_start || w_win_close) begin
                    r_win_len     <= w_win_len_new;
                    r_frame_cnt   <= '0;
                    r_frame_oflow <= w_any;
                    r_lane_mask   <= w_mask_in;
                end else if (w_sync_acc) begin
                    r_frame_cnt   <= r_frame_cnt + WIN_W'(1);
                    r_frame_oflow <= w_any;
                    r_lane_mask   <= r_lane_mask | w_mask_in;
                end else if (w_active) begin
                    r_frame_oflow <= r_frame_oflow | w_any;
                    r_lane_mask   <= r_lane_mask | w_mask_in;
                end
            end
        end
    end

    assign bus.status_word  = r_status;
    assign bus.status_valid = r_status_valid;
    assign bus.sticky_oflow = r_sticky;
endmodule

// File: tb/tb_fft_oflow_ctrl.sv
// Scenario-driven bench for fft_oflow_ctrl with a queue of expected status words.
module tb_fft_oflow_ctrl;
    logic clk;
    logic rst_n;

    fft_oflow_ctrl_if #(.NUM_LANES(4), .WIN_W(16)) bus ();

    fft_oflow_ctrl #(.NUM_LANES(4), .WIN_W(16), .CNT_W(12)) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .bus        (bus)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_pulses_seen = 0;
    int          n_pulses_exp = 0;
    logic [31:0] exp_q[$];
    logic [31:0] w_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.status_valid === 1'b1) n_pulses_seen <= n_pulses_seen + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n, input logic [3:0] ofl);
        bus.fft_sync  = 1'b0;
        bus.fft_oflow = ofl;
        repeat (n) tick();
        bus.fft_oflow = 4'h0;
    endtask

    task automatic pulse_sync(input logic [3:0] ofl);
        bus.fft_sync  = 1'b1;
        bus.fft_oflow = ofl;
        tick();
        bus.fft_sync  = 1'b0;
        bus.fft_oflow = 4'h0;
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
        n_pulses_exp++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.clear = 1'b0;
        bus.fft_sync = 1'b0;
        bus.fft_oflow = 4'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.clear = 1'b0;
        bus.win_frames = 16'd1;
        bus.fft_sync = 1'b1;
        bus.fft_oflow = 4'hF;
        repeat (3) tick();
        n_checks += 3;
        if (bus.status_word !== 32'h0) $display("FAIL reset_word: got %h want 00000000", bus.status_word); else n_pass++;
        if (bus.status_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.status_valid); else n_pass++;
        if (bus.sticky_oflow !== 1'b0) $display("FAIL reset_sticky: got %b want 0", bus.sticky_oflow); else n_pass++;
        do_reset();
    endtask

    task automatic test_basic_window();
        do_reset();
        bus.win_frames = 16'd4;
        bus.enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            pulse_sync(4'h0);
            run_cycles(15, 4'h0);
        end
        n_checks++;
        if (n_pulses_seen !== n_pulses_exp) $display("FAIL basic_early: pulses %0d want %0d", n_pulses_seen, n_pulses_exp); else n_pass++;
        push_exp(32'h0000_0000);
        pulse_sync(4'h0);
        n_checks += 2;
        if (bus.status_valid !== 1'b1) $display("FAIL basic_latency: status_valid=%b want 1", bus.status_valid); else n_pass++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL basic_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
        tick();
        n_checks++;
        if (bus.status_valid !== 1'b0) $display("FAIL basic_pulse_width: status_valid=%b want 0", bus.status_valid); else n_pass++;
        run_cycles(14, 4'h0);
        for (int i = 0; i < 3; i++) begin
            pulse_sync(4'h0);
            run_cycles(15, 4'h0);
        end
        push_exp(32'h1000_0000);
        pulse_sync(4'h0);
        n_checks += 2;
        if (bus.status_valid !== 1'b1) $display("FAIL basic_valid2: status_valid=%b want 1", bus.status_valid); else n_pass++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL basic_seq: got %h want %h", bus.status_word, w_exp); else n_pass++;
    endtask

    task automatic test_lane_oflow();
        do_reset();
        bus.win_frames = 16'd2;
        bus.enable = 1'b1;
        tick();
        pulse_sync(4'h0);
        run_cycles(2, 4'h0);
        run_cycles(3, 4'b0010);
        run_cycles(10, 4'h0);
        pulse_sync(4'h0);
        run_cycles(4, 4'h0);
        run_cycles(1, 4'b1000);
        run_cycles(5, 4'h0);
        push_exp(32'h8A00_2004);
        pulse_sync(4'h0);
        n_checks += 3;
        if (bus.status_valid !== 1'b1) $display("FAIL lane_valid: status_valid=%b want 1", bus.status_valid); else n_pass++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL lane_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
        if (bus.sticky_oflow !== 1'b1) $display("FAIL lane_sticky: got %b want 1", bus.sticky_oflow); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        bus.win_frames = 16'd1;
        bus.enable = 1'b1;
        tick();
        pulse_sync(4'h0);
        run_cycles(5000, 4'hF);
        push_exp(32'h8F00_1FFF);
        pulse_sync(4'h0);
        n_checks += 2;
        if (bus.status_valid !== 1'b1) $display("FAIL samp_sat_valid: status_valid=%b want 1", bus.status_valid); else n_pass++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL samp_sat_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
        // 4201 back-to-back syncs with flags set drive both counters past 4095
        do_reset();
        bus.win_frames = 16'd4200;
        bus.enable = 1'b1;
        tick();
        bus.fft_sync = 1'b1;
        bus.fft_oflow = 4'hF;
        repeat (4200) tick();
        push_exp(32'h8FFF_FFFF);
        tick();
        bus.fft_sync = 1'b0;
        bus.fft_oflow = 4'h0;
        n_checks += 2;
        if (bus.status_valid !== 1'b1) $display("FAIL frm_sat_valid: status_valid=%b want 1", bus.status_valid); else n_pass++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL frm_sat_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
    endtask

    task automatic test_clear();
        do_reset();
        bus.win_frames = 16'd2;
        bus.enable = 1'b1;
        tick();
        pulse_sync(4'h0);
        run_cycles(3, 4'b0001);
        run_cycles(5, 4'h0);
        pulse_sync(4'h0);
        run_cycles(5, 4'h0);
        push_exp(32'h8100_1003);
        pulse_sync(4'h0);
        n_checks++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL clear_pre_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
        run_cycles(5, 4'b0100);
        pulse_sync(4'h0);
        run_cycles(5, 4'h0);
        bus.clear = 1'b1;
        pulse_sync(4'h0);
        bus.clear = 1'b0;
        n_checks += 3;
        if (bus.status_valid !== 1'b0) $display("FAIL clear_valid: status_valid=%b want 0", bus.status_valid); else n_pass++;
        if (bus.status_word !== 32'h0) $display("FAIL clear_word: got %h want 00000000", bus.status_word); else n_pass++;
        if (bus.sticky_oflow !== 1'b0) $display("FAIL clear_sticky: got %b want 0", bus.sticky_oflow); else n_pass++;
        run_cycles(3, 4'h0);
        pulse_sync(4'h0);
        run_cycles(2, 4'h0);
        run_cycles(1, 4'b0001);
        run_cycles(2, 4'h0);
        pulse_sync(4'h0);
        n_checks++;
        if (bus.status_valid !== 1'b0) $display("FAIL clear_realign: status_valid=%b want 0", bus.status_valid); else n_pass++;
        run_cycles(3, 4'h0);
        push_exp(32'h8100_1001);
        pulse_sync(4'h0);
        n_checks += 2;
        if (bus.status_valid !== 1'b1) $display("FAIL clear_post_valid: status_valid=%b want 1", bus.status_valid); else n_pass++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL clear_post_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
    endtask

    task automatic test_enable_drop();
        do_reset();
        bus.win_frames = 16'd2;
        bus.enable = 1'b1;
        tick();
        pulse_sync(4'h0);
        run_cycles(2, 4'b0010);
        run_cycles(3, 4'h0);
        pulse_sync(4'h0);
        run_cycles(3, 4'h0);
        push_exp(32'h8200_1002);
        pulse_sync(4'h0);
        n_checks++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL en_first_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
        run_cycles(3, 4'b0100);
        bus.enable = 1'b0;
        tick();
        run_cycles(2, 4'h0);
        pulse_sync(4'h0);
        run_cycles(2, 4'h0);
        n_checks += 2;
        if (bus.status_word !== 32'h8200_1002) $display("FAIL en_hold_word: got %h want 82001002", bus.status_word); else n_pass++;
        if (n_pulses_seen !== n_pulses_exp) $display("FAIL en_no_pulse: pulses %0d want %0d", n_pulses_seen, n_pulses_exp); else n_pass++;
        bus.enable = 1'b1;
        tick();
        run_cycles(3, 4'b1000);
        pulse_sync(4'h0);
        run_cycles(2, 4'h0);
        pulse_sync(4'h0);
        run_cycles(2, 4'h0);
        push_exp(32'h9000_0000);
        pulse_sync(4'h0);
        n_checks += 2;
        if (bus.status_valid !== 1'b1) $display("FAIL en_re_valid: status_valid=%b want 1", bus.status_valid); else n_pass++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL en_re_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
    endtask

    task automatic test_win_len();
        do_reset();
        bus.win_frames = 16'd0;
        bus.enable = 1'b1;
        tick();
        pulse_sync(4'h0);
        run_cycles(3, 4'h0);
        push_exp(32'h0000_0000);
        pulse_sync(4'h0);
        n_checks += 2;
        if (bus.status_valid !== 1'b1) $display("FAIL win0_valid: status_valid=%b want 1", bus.status_valid); else n_pass++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL win0_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
        run_cycles(2, 4'h0);
        bus.win_frames = 16'd1;
        run_cycles(1, 4'h0);
        push_exp(32'h1000_0000);
        pulse_sync(4'h0);
        run_cycles(2, 4'h0);
        bus.win_frames = 16'd3;
        run_cycles(2, 4'h0);
        push_exp(32'h2000_0000);
        pulse_sync(4'h0);
        n_checks += 2;
        if (bus.status_valid !== 1'b1) $display("FAIL win_old_len_valid: status_valid=%b want 1", bus.status_valid); else n_pass++;
        w_exp = exp_q.pop_front();
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL win_old_len_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            run_cycles(2, 4'h0);
            pulse_sync(4'h0);
            n_checks++;
            if (bus.status_valid !== 1'b0) $display("FAIL win_new_len_mid%0d: status_valid=%b want 0", i, bus.status_valid); else n_pass++;
        end
        run_cycles(2, 4'h0);
        push_exp(32'h3000_0000);
        pulse_sync(4'h0);
        n_checks += 2;
        if (bus.status_valid !== 1'b1) $display("FAIL win_new_len_valid: status_valid=%b want 1", bus.status_valid); else n_pass++;
        w_exp = exp_q.pop_front();
        if (bus.status_word !== w_exp) $display("FAIL win_new_len_word: got %h want %h", bus.status_word, w_exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.win_frames = 16'd1;
        bus.enable = 1'b1;
        tick();
        bus.fft_sync = 1'b1;
        bus.fft_oflow = 4'b0001;
        tick();
        for (int i = 0; i < 3; i++) begin
            push_exp({1'b1, 3'(i), 28'h100_1001});
            tick();
            n_checks += 2;
            if (bus.status_valid !== 1'b1) $display("FAIL b2b_valid%0d: status_valid=%b want 1", i, bus.status_valid); else n_pass++;
            w_exp = exp_q.pop_front();
            if (bus.status_word !== w_exp) $display("FAIL b2b_word%0d: got %h want %h", i, bus.status_word, w_exp); else n_pass++;
        end
        bus.fft_sync = 1'b0;
        bus.fft_oflow = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.clear = 1'b0;
        bus.win_frames = 16'd1;
        bus.fft_sync = 1'b0;
        bus.fft_oflow = 4'h0;
        test_reset();
        test_basic_window();
        test_lane_oflow();
        test_saturation();
        test_clear();
        test_enable_drop();
        test_win_len();
        test_back_to_back();
        bus.enable = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (n_pulses_seen !== n_pulses_exp) $display("FAIL pulse_total: pulses %0d want %0d", n_pulses_seen, n_pulses_exp); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
